// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding plus the instruction width and PC step.
package fetch_ctrl_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        IDLE  = 2'd1,
        REQ   = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_target_sel.sv
// Priority redirect select (trap > mret > branch) with word-aligned target.
// Purely combinational; no state, no backpressure.
module fetch_target_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_width = 32
) (
    input  logic                trap_req,
    input  logic                mret_req,
    input  logic                redirect_valid,
    input  logic [PC_width-1:0] trap_vec,
    input  logic [PC_width-1:0] epc,
    input  logic [PC_width-1:0] redirect_pc,
    output logic                redir,
    output logic [PC_width-1:0] target
);

    always_comb begin
        redir = trap_req | mret_req | redirect_valid;
        if (trap_req) begin
            target = trap_vec;
        end else if (mret_req) begin
            target = epc;
        end else begin
            target = redirect_pc;
        end
        target[1:0] = 2'b00;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, redirects flush it.
// Delivery is a registered pulse the cycle after ack; stall only blocks new issue.
// Define FETCH_CTRL_TRAP_EN to enable trap/mret redirects and the saved EPC.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                   PC_width  = 32,
    parameter logic [PC_width-1:0]  RESET_VEC = 32'h0000_0000,
    parameter logic [PC_width-1:0]  TRAP_VEC  = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                redirect_valid,
    input  logic [PC_width-1:0] redirect_pc,
    input  logic                trap_req,
    input  logic                mret_req,
    input  logic [PC_width-1:0] trap_epc,
    output logic                imem_req,
    output logic [PC_width-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_width-1:0] instr_pc,
    output logic [PC_width-1:0] pc_out,
    output logic [PC_width-1:0] epc_out
);

    state_t              state, state_nxt;
    logic [PC_width-1:0] pend, pend_nxt, pc_nxt, target;
    logic                redir, deliver, trap_en, mret_en;

`ifdef FETCH_CTRL_TRAP_EN
    assign trap_en = trap_req;
    assign mret_en = mret_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_out <= '0;
        end else if (trap_req && state != BOOT) begin
            epc_out <= trap_epc;
        end
    end
`else
    logic unused_trap;
    assign trap_en     = 1'b0;
    assign mret_en     = 1'b0;
    assign epc_out     = '0;
    assign unused_trap = ^{trap_req, mret_req, trap_epc};
`endif

    fetch_target_sel #(.PC_width(PC_width)) u_sel (
        .trap_req       (trap_en),
        .mret_req       (mret_en),
        .redirect_valid (redirect_valid),
        .trap_vec       (TRAP_VEC),
        .epc            (epc_out),
        .redirect_pc    (redirect_pc),
        .redir          (redir),
        .target         (target)
    );

    // pc only moves on ack (or in IDLE), so imem_addr is stable for a whole request.
    assign imem_addr = pc_out;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
        pend_nxt  = pend;
        deliver   = 1'b0;
        imem_req  = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = stall_i ? IDLE : REQ;
            end
            IDLE: begin
                if (redir) pc_nxt = target;
                if (!stall_i) state_nxt = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = redir ? target : pc_out + PC_width'(PC_INC);
                    deliver   = !redir;
                    state_nxt = stall_i ? IDLE : REQ;
                end else if (redir) begin
                    pend_nxt  = target;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = redir ? target : pend;
                    state_nxt = stall_i ? IDLE : REQ;
                end else if (redir) begin
                    pend_nxt = target;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_out      <= RESET_VEC;
            pend        <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc_out      <= pc_nxt;
            pend        <= pend_nxt;
            instr_valid <= deliver;
            if (deliver) begin
                instr    <= imem_rdata;
                instr_pc <= pc_out;
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_width, default 32, width of all address/PC buses.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, trap target address.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-low):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous active-low reset
  stall_i  in  1  inhibit issue of a new fetch
  redirect_valid  in  1  branch/jump taken
  redirect_pc  in  PC_width  branch/jump target
  trap_req  in  1  take trap
  mret_req  in  1  return from trap
  trap_epc  in  PC_width  PC to save on trap
  imem_req  out  1  fetch request
  imem_addr  out  PC_width  fetch address
  imem_ack  in  1  fetch complete, imem_rdata valid
  imem_rdata  in  32  fetched instruction
  instr_valid  out  1  instruction delivered
  instr  out  32  delivered instruction
  instr_pc  out  PC_width  address of delivered instruction
  pc_out  out  PC_width  current PC register
  epc_out  out  PC_width  saved exception PC

Function
REQ-005 SHALL implement FSM states BOOT, IDLE, REQ, FLUSH.
REQ-006 BOOT: imem_req=0; next IDLE if stall_i else REQ.
REQ-007 IDLE: imem_req=0; next REQ when stall_i=0; redirect in IDLE loads pc directly.
REQ-008 REQ: imem_req=1, imem_addr=pc_out; imem_addr SHALL stay stable until ack.
REQ-009 REQ, ack, no redirect: pc<=pc+4; next cycle instr_valid=1, instr=imem_rdata, instr_pc=acked address; next state IDLE if stall_i else REQ.
REQ-010 REQ, ack with redirect same cycle: pc<=target, delivery suppressed (instr_valid=0).
REQ-011 REQ, redirect without ack: target into pending register, next FLUSH.
REQ-012 FLUSH: imem_req=1, same address; on ack data discarded, pc<=pending target, next IDLE/REQ per stall_i; new redirect in FLUSH overwrites pending target (latest wins).
REQ-013 instr_valid SHALL be a single-cycle registered pulse per delivered instruction, never asserted for discarded fetches.
REQ-014 Redirect priority: trap_req > mret_req > redirect_valid.
REQ-015 Target bits [1:0] SHALL be forced to 0; pc+4 wraps modulo 2^PC_width.
REQ-016 stall_i SHALL NOT drop an active imem_req; it only blocks issue of the next request.
REQ-017 imem_ack outside REQ/FLUSH SHALL be ignored.

Reset
REQ-018 rst_n=0 at a rising clk edge: state=BOOT, pc_out=RESET_VEC, pending=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, epc_out=0.
REQ-019 Reset mid-handshake SHALL abandon the fetch; a late ack in BOOT is ignored.

Configuration
REQ-020 Macro FETCH_CTRL_TRAP_EN defined: trap_req redirects to TRAP_VEC and latches trap_epc into epc_out; mret_req redirects to epc_out.
REQ-021 Macro undefined: ports remain, trap_req/mret_req/trap_epc ignored, epc_out constant 0.

Structure
REQ-022 Package fetch_ctrl_pkg SHALL hold FSM state enum and the instruction-width (32) and PC-increment (4) constants.
REQ-023 One sub-module fetch_target_sel SHALL implement the combinational priority target select and low-bit masking.

Verification
REQ-024 Reset release, stall_i=0, ack each request one cycle after issue -> imem_addr 0x0,0x4,0x8; instr_pc matches; one instr_valid per ack.
REQ-025 redirect_valid, redirect_pc=0x1003 while REQ at 0x8 unacked -> 0x8 held until ack, no instr_valid for it, next imem_addr=0x1000.
REQ-026 stall_i=1 during REQ -> request completes and delivers, then imem_req=0 until stall_i=0; pc_out holds.
REQ-027 With FETCH_CTRL_TRAP_EN: trap_req, trap_epc=0x40, redirect same cycle -> next fetch 0x100, epc_out=0x40; mret_req -> fetch 0x40.
REQ-028 pc_out=0xFFFF_FFFC acked -> next imem_addr=0x0.
REQ-029 rst_n=0 during FLUSH with ack one cycle later -> pc_out=RESET_VEC, instr_valid stays 0, fetch restarts at RESET_VEC.
